// File: rtl/tcp_rx_checker_if.sv
// SiTCPXG receive-buffer port bundle as seen by the RX test-pattern checker.
interface tcp_rx_checker_if;
    logic        SiTCPXG_ESTABLISHED;
    logic [15:0] SiTCPXG_RX_SIZE;
    logic        SiTCPXG_RX_CLR_ENB;
    logic        SiTCPXG_RX_CLR_REQ;
    logic [15:0] SiTCPXG_RX_RADR;
    logic [15:0] SiTCPXG_RX_WADR;
    logic [7:0]  SiTCPXG_RX_WENB;
    logic [63:0] SiTCPXG_RX_WDAT;

    // SiTCPXG core side
    modport master (
        output SiTCPXG_ESTABLISHED, SiTCPXG_RX_CLR_ENB, SiTCPXG_RX_WADR,
               SiTCPXG_RX_WENB, SiTCPXG_RX_WDAT,
        input  SiTCPXG_RX_SIZE, SiTCPXG_RX_CLR_REQ, SiTCPXG_RX_RADR
    );

    // checker side
    modport slave (
        input  SiTCPXG_ESTABLISHED, SiTCPXG_RX_CLR_ENB, SiTCPXG_RX_WADR,
               SiTCPXG_RX_WENB, SiTCPXG_RX_WDAT,
        output SiTCPXG_RX_SIZE, SiTCPXG_RX_CLR_REQ, SiTCPXG_RX_RADR
    );
endinterface

// File: rtl/tcp_rx_checker.sv
// Receive-side checker: compares received bytes against an incrementing 8-bit
// counter stream (first byte 0x01) and reports byte/error counts. The buffer is
// released as soon as bytes are written; no data is stored.
module tcp_rx_checker #(
    parameter logic [15:0] RX_BUF_SIZE = 16'd4000,
    parameter int unsigned ERR_CNT_W   = 32
) (
    input  logic                 CLK156M,
    input  logic                 RSTs,
    input  logic                 CHK_ENB,
    input  logic                 CLR_CNT,
    tcp_rx_checker_if.slave      sitcp,
    output logic [63:0]          RX_BYTE_CNT,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic                 ERR_FLAG,
    output logic [63:0]          ERR_FIRST_POS,
    output logic [15:0]          ERR_FIRST_DATA
);

    typedef enum logic {IDLE, SESS} state_t;

    state_t state_q, state_d;
    logic   sess_start, clr, beat;

    logic        clr_req_q;
    logic [15:0] radr_q, radr_d;
    logic [2:0]  low_lane;

    // S0 capture
    logic        in_vld_q;
    logic [7:0]  in_wenb_q;
    logic [63:0] in_wdat_q;

    // S1 compare
    logic [7:0]  exp_q, exp_d, lane_exp, lane_dat;
    logic [3:0]  n_d, mis_cnt_d;
    logic        mis_any_d;
    logic [2:0]  off_d;
    logic [15:0] fdata_d;
    logic        cmp_vld_q, cmp_mis_q;
    logic [3:0]  cmp_n_q, cmp_mis_cnt_q;
    logic [2:0]  cmp_off_q;
    logic [15:0] cmp_fdata_q;

    // S2 accumulate
    logic [63:0]          byte_cnt_q, byte_cnt_d, pos_q, pos_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W:0]   err_sum;
    logic                 flag_q, flag_d;
    logic [15:0]          first_data_q, first_data_d;

    // session FSM: entering SESS clears all counters like CLR_CNT
    always_comb begin
        state_d    = state_q;
        sess_start = 1'b0;
        unique case (state_q)
            IDLE: if (sitcp.SiTCPXG_ESTABLISHED) begin
                state_d    = SESS;
                sess_start = 1'b1;
            end
            SESS: if (!sitcp.SiTCPXG_ESTABLISHED) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign clr  = CLR_CNT | sess_start;
    assign beat = (state_q == SESS) && (sitcp.SiTCPXG_RX_WENB != 8'h00);

    // read pointer: jump to WADR on buffer clear, else one past the last byte written
    always_comb begin
        low_lane = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sitcp.SiTCPXG_RX_WENB[7-i]) low_lane = 3'(7 - i);
        end
        radr_d = radr_q;
        if (clr_req_q)
            radr_d = sitcp.SiTCPXG_RX_WADR;
        else if (beat)
            radr_d = {sitcp.SiTCPXG_RX_WADR[15:3], 3'b000} + 16'd8 - {13'd0, low_lane};
    end

    // S1: per-lane expected values, walking lanes from bit7 so gaps do not advance the count
    always_comb begin
        n_d       = '0;
        mis_cnt_d = '0;
        mis_any_d = 1'b0;
        off_d     = '0;
        fdata_d   = '0;
        lane_exp  = '0;
        lane_dat  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (in_wenb_q[7-i]) begin
                lane_exp = exp_q + {4'd0, n_d};
                lane_dat = in_wdat_q[8*(7-i) +: 8];
                if (CHK_ENB && (lane_dat != lane_exp)) begin
                    mis_cnt_d = mis_cnt_d + 4'd1;
                    if (!mis_any_d) begin
                        mis_any_d = 1'b1;
                        off_d     = n_d[2:0];
                        fdata_d   = {lane_exp, lane_dat};
                    end
                end
                n_d = n_d + 4'd1;
            end
        end
    end

    assign err_sum = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(cmp_mis_cnt_q);

    // S2 and expected-byte update; a clear overrides any in-flight beat
    always_comb begin
        exp_d        = exp_q;
        byte_cnt_d   = byte_cnt_q;
        err_cnt_d    = err_cnt_q;
        flag_d       = flag_q;
        pos_d        = pos_q;
        first_data_d = first_data_q;
        if (in_vld_q) exp_d = exp_q + {4'd0, n_d};
        if (cmp_vld_q) begin
            byte_cnt_d = byte_cnt_q + 64'(cmp_n_q);
            err_cnt_d  = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
            if (!flag_q && cmp_mis_q) begin
                flag_d       = 1'b1;
                pos_d        = byte_cnt_q + 64'(cmp_off_q);
                first_data_d = cmp_fdata_q;
            end
        end
        if (clr) begin
            exp_d        = 8'h01;
            byte_cnt_d   = '0;
            err_cnt_d    = '0;
            flag_d       = 1'b0;
            pos_d        = '0;
            first_data_d = '0;
        end
    end

    // state registers
    always_ff @(posedge CLK156M or posedge RSTs) begin
        if (RSTs) begin
            state_q       <= IDLE;
            clr_req_q     <= 1'b0;
            radr_q        <= '0;
            in_vld_q      <= 1'b0;
            in_wenb_q     <= '0;
            in_wdat_q     <= '0;
            exp_q         <= 8'h01;
            cmp_vld_q     <= 1'b0;
            cmp_mis_q     <= 1'b0;
            cmp_n_q       <= '0;
            cmp_mis_cnt_q <= '0;
            cmp_off_q     <= '0;
            cmp_fdata_q   <= '0;
            byte_cnt_q    <= '0;
            err_cnt_q     <= '0;
            flag_q        <= 1'b0;
            pos_q         <= '0;
            first_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            clr_req_q     <= sitcp.SiTCPXG_RX_CLR_ENB;
            radr_q        <= radr_d;
            in_vld_q      <= beat & ~clr;
            in_wenb_q     <= sitcp.SiTCPXG_RX_WENB;
            in_wdat_q     <= sitcp.SiTCPXG_RX_WDAT;
            exp_q         <= exp_d;
            cmp_vld_q     <= in_vld_q & ~clr;
            cmp_mis_q     <= mis_any_d;
            cmp_n_q       <= n_d;
            cmp_mis_cnt_q <= mis_cnt_d;
            cmp_off_q     <= off_d;
            cmp_fdata_q   <= fdata_d;
            byte_cnt_q    <= byte_cnt_d;
            err_cnt_q     <= err_cnt_d;
            flag_q        <= flag_d;
            pos_q         <= pos_d;
            first_data_q  <= first_data_d;
        end
    end

    assign sitcp.SiTCPXG_RX_SIZE    = RX_BUF_SIZE;
    assign sitcp.SiTCPXG_RX_CLR_REQ = clr_req_q;
    assign sitcp.SiTCPXG_RX_RADR    = radr_q;
    assign RX_BYTE_CNT              = byte_cnt_q;
    assign ERR_CNT                  = err_cnt_q;
    assign ERR_FLAG                 = flag_q;
    assign ERR_FIRST_POS            = pos_q;
    assign ERR_FIRST_DATA           = first_data_q;

endmodule
